// File: rtl/card_blitter.sv
// rtl/card_blitter.sv - sprite-to-framebuffer copy engine with transparency and screen clipping
module card_blitter #(
    parameter int         SPR_W  = 16,
    parameter int         SPR_H  = 32,
    parameter logic [2:0] TRANSP = 3'b000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [7:0]  y0,
    output logic        busy,
    output logic        done,
    output logic        spr_RE,
    output logic [8:0]  spr_rAddr,
    input  logic [2:0]  spr_data,
    output logic        fb_WE,
    output logic [15:0] fb_wAddr,
    output logic [2:0]  fb_data
);

    localparam int N = SPR_W * SPR_H;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t      state;
    logic [7:0]  x_org;
    logic [7:0]  y_org;
    logic [7:0]  rd_row;
    logic [7:0]  rd_col;
    logic [7:0]  wr_row;
    logic [7:0]  wr_col;
    logic        wr_valid;
    logic [15:0] addr_q;
    logic [2:0]  data_q;
    logic [8:0]  sx;
    logic [8:0]  sy;

    // Write stage sees the (row, col) of the read issued one cycle earlier,
    // aligned with the memory's registered dataOut.
    assign sx = {1'b0, x_org} + {1'b0, wr_col};
    assign sy = {1'b0, y_org} + {1'b0, wr_row};

    assign fb_WE    = wr_valid && (spr_data != TRANSP) && (sx <= 9'd255) && (sy <= 9'd239);
    assign fb_wAddr = fb_WE ? {sy[7:0], sx[7:0]} : addr_q;
    assign fb_data  = fb_WE ? spr_data : data_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            x_org     <= 8'd0;
            y_org     <= 8'd0;
            rd_row    <= 8'd0;
            rd_col    <= 8'd0;
            wr_row    <= 8'd0;
            wr_col    <= 8'd0;
            wr_valid  <= 1'b0;
            addr_q    <= 16'd0;
            data_q    <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spr_RE    <= 1'b0;
            spr_rAddr <= 9'd0;
        end else begin
            wr_valid <= spr_RE;
            wr_row   <= rd_row;
            wr_col   <= rd_col;
            if (fb_WE) begin
                addr_q <= fb_wAddr;
                data_q <= spr_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        x_org     <= x0;
                        y_org     <= y0;
                        rd_row    <= 8'd0;
                        rd_col    <= 8'd0;
                        spr_rAddr <= 9'd0;
                        spr_RE    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (spr_rAddr == 9'(N - 1)) begin
                        spr_RE <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        spr_rAddr <= spr_rAddr + 9'd1;
                        if (rd_col == 8'(SPR_W - 1)) begin
                            rd_col <= 8'd0;
                            rd_row <= rd_row + 8'd1;
                        end else begin
                            rd_col <= rd_col + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_blitter.sv
// tb/tb_card_blitter.sv - scoreboard bench for card_blitter
module tb_card_blitter;

    localparam int SPR_W = 16;
    localparam int SPR_H = 32;
    localparam int N     = SPR_W * SPR_H;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  x0 = 8'd0;
    logic [7:0]  y0 = 8'd0;
    logic        busy;
    logic        done;
    logic        spr_RE;
    logic [8:0]  spr_rAddr;
    logic [2:0]  spr_data = 3'd0;
    logic        fb_WE;
    logic [15:0] fb_wAddr;
    logic [2:0]  fb_data;

    logic [2:0]  mem [N];

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [2:0]  data;
    } wr_t;

    wr_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int base = 0;
    int rel = 0;
    int wr_cnt = 0;
    bit tracking = 1'b0;

    card_blitter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .busy      (busy),
        .done      (done),
        .spr_RE    (spr_RE),
        .spr_rAddr (spr_rAddr),
        .spr_data  (spr_data),
        .fb_WE     (fb_WE),
        .fb_wAddr  (fb_wAddr),
        .fb_data   (fb_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        edge_cnt <= edge_cnt + 1;
        if (spr_RE) spr_data <= mem[spr_rAddr];
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, rel);
        end
    endtask

    // One clock: sample on the falling edge and compare against the scoreboard.
    task automatic step();
        bit exp_we;
        wr_t w;
        @(negedge clock);
        rel = edge_cnt - base;
        exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == rel);
        check("fb_we", int'(fb_WE), int'(exp_we));
        if (fb_WE) wr_cnt++;
        if (fb_WE && exp_we) begin
            w = exp_q.pop_front();
            check("fb_waddr", int'(fb_wAddr), int'(w.addr));
            check("fb_data", int'(fb_data), int'(w.data));
        end
        check("busy", int'(busy), int'(tracking && rel >= 1 && rel <= N + 1));
        check("done", int'(done), int'(tracking && rel == N + 2));
        check("spr_re", int'(spr_RE), int'(tracking && rel >= 1 && rel <= N));
        if (spr_RE) check("spr_raddr", int'(spr_rAddr), rel - 1);
    endtask

    task automatic launch(input int x, input int y);
        int sx, sy;
        start    = 1'b1;
        x0       = 8'(x);
        y0       = 8'(y);
        base     = edge_cnt;
        rel      = 0;
        tracking = 1'b1;
        wr_cnt   = 0;
        for (int n = 0; n < N; n++) begin
            sx = x + n % SPR_W;
            sy = y + n / SPR_W;
            if (mem[n] != 3'd0 && sx <= 255 && sy <= 239)
                exp_q.push_back('{n + 2, 16'(sy * 256 + sx), mem[n]});
        end
        step();
        start = 1'b0;
        x0    = 8'($urandom);
        y0    = 8'($urandom);
    endtask

    task automatic run_to(input int r);
        while (rel < r) step();
    endtask

    task automatic finish_blit(input string tag, input int nwr);
        run_to(N + 3);
        check({tag, "_wr_count"}, wr_cnt, nwr);
        check({tag, "_q_left"}, exp_q.size(), 0);
    endtask

    initial begin
        for (int n = 0; n < N; n++) mem[n] = 3'((n % 7) + 1);

        // Reset held with start asserted
        reset_n = 1'b0;
        start   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_waddr", int'(fb_wAddr), 0);
            check("rst_fbdata", int'(fb_data), 0);
            check("rst_raddr", int'(spr_rAddr), 0);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Full blit at origin
        launch(0, 0);
        finish_blit("full", 512);

        // Transparency: only pixel 17 is opaque
        for (int n = 0; n < N; n++) mem[n] = 3'd0;
        mem[17] = 3'b101;
        launch(10, 20);
        finish_blit("transp", 1);

        // Clipping against right and bottom edges
        for (int n = 0; n < N; n++) mem[n] = 3'((n % 7) + 1);
        launch(250, 230);
        finish_blit("clip", 60);

        // Start during a blit is ignored; next start accepted at cycle 516
        launch(3, 5);
        run_to(100);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(516);
        check("ign_q_left", exp_q.size(), 0);
        check("ign_wr_count", wr_cnt, 512);
        launch(40, 60);
        finish_blit("restart", 512);

        // Reset in the middle of a blit
        launch(0, 0);
        run_to(100);
        reset_n  = 1'b0;
        tracking = 1'b0;
        exp_q.delete();
        step();
        check("mid_waddr", int'(fb_wAddr), 0);
        check("mid_fbdata", int'(fb_data), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 600; i++) step();
        launch(100, 100);
        finish_blit("post_rst", 512);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/card_blitter.md
# card_blitter

Copy engine that reads a card sprite out of a 512-entry, 3-bit-per-pixel sprite memory and writes it into the 256x240 framebuffer at a requested screen position. It drives the read side of the sprite memory (RE, rAddr, dataOut with one-cycle registered read latency) and the write side of the framebuffer memory (WE, wAddr, dataIn). Transparent pixels are skipped, and off-screen pixels are clipped. The game logic drives it with a start/busy/done handshake.

## Interface
- SPR_W, 16: sprite width in pixels
- SPR_H, 32: sprite height in pixels; SPR_W*SPR_H <= 512
- TRANSP, 3'b000: colour code treated as transparent (never written)
- clock  in  1  system clock, all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only while idle
- x0  in  8  screen column of sprite's top-left pixel, latched on accepted start
- y0  in  8  screen row of sprite's top-left pixel, latched on accepted start
- busy  out  1  high while a blit is in progress
- done  out  1  one-cycle pulse after the last pixel slot
- spr_RE  out  1  sprite memory read enable
- spr_rAddr  out  9  sprite memory read address
- spr_data  in  3  sprite memory dataOut; valid one cycle after spr_RE
- fb_WE  out  1  framebuffer write enable
- fb_wAddr  out  16  framebuffer write address, {row[7:0], col[7:0]}
- fb_data  out  3  framebuffer write data

## Operation
- FSM states:
  - IDLE
    - start=1 latches x0/y0, clears row/col counters, goes to READ.
    - start=0 stays in IDLE.
  - READ
    - Each cycle: spr_RE=1, spr_rAddr=row*SPR_W+col, then col advances.
    - At col=SPR_W-1, col wraps to 0 and row increments.
    - After issuing address SPR_W*SPR_H-1, goes to DRAIN.
  - DRAIN: one cycle to consume the last read datum, then goes to DONE.
  - DONE: done=1 for one cycle, then goes to IDLE.
- Write stage is pipelined one cycle behind reads. The (row, col) of each issued read is registered alongside a valid bit. When that data returns:
  - Screen position: sx = x0+col and sy = y0+row, each a 9-bit sum.
  - fb_WE=1 only if valid, spr_data != TRANSP, sx <= 255 and sy <= 239.
  - fb_wAddr = {sy[7:0], sx[7:0]}, fb_data = spr_data.
- Clipped or transparent pixels still consume their cycle. Blit length is fixed regardless of content.
- start is ignored while busy=1 or done=1.
- Reset mid-blit: next cycle in IDLE with all outputs 0. No further reads or writes are issued, and no done pulse is generated.
- x0/y0 changes after the accepted start have no effect on the blit in progress.

## Timing
- Reset values: busy=0, done=0, spr_RE=0, spr_rAddr=0, fb_WE=0, fb_wAddr=0, fb_data=0; FSM in IDLE.
- Let N = SPR_W*SPR_H (512 by default). start sampled high at edge of cycle 0.
- Cycles 1..N: spr_RE=1, with spr_rAddr = cycle-1.
- Cycles 2..N+1: write slot for pixel cycle-2.
- Cycle N+2: done=1, busy=0.
- busy=1 during cycles 1..N+1.
- Total latency start to done is N+2 = 514 cycles at default parameters.
- Earliest next accepted start: cycle N+3.
- Outside the write slots, fb_WE=0 and spr_RE=0. fb_wAddr/fb_data hold their last value when disabled.

## Test plan
- Reset: hold reset_n=0 for 3 cycles while start=1 -> all outputs 0, no writes; release -> still idle until a start pulse.
- Full blit at (0,0), sprite mem[n]=(n%7)+1 -> exactly 512 writes. Pixel n goes to fb_wAddr=(n/16)*256+(n%16) with data (n%7)+1, in cycle n+2. done at cycle 514 only; busy high cycles 1..513.
- Transparency: sprite all 3'b000 except mem[17]=3'b101, blit at (10,20) -> single write, fb_wAddr=21*256+11=5387, data 5, in cycle 19; done still at cycle 514.
- Clipping: all-nonzero sprite at (250,230) -> 60 writes, cols 250..255 by rows 230..239. No write with col or row outside that range; done at cycle 514.
- Ignored start: pulse start at cycles 0 and 100 -> one blit only; at cycle 516, start accepted for a new blit.
- Mid-blit reset: reset_n=0 at cycle 100 -> cycle 101 busy=0, spr_RE=0, fb_WE=0. No further writes and no done pulse; a later start performs a full 514-cycle blit.
